// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
// The master side drives operands and out_ready; the slave side is the subtractor.
interface serial_subtractor_if #(
    parameter int C_WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [C_WIDTH-1:0] diff;
    logic               borrow;
    logic               ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: a - b computed as a + ~b + 1, one C_DIGIT-bit digit per
// clock, least-significant digit first, with the carry held in a register between digits.
module serial_subtractor #(
    parameter int C_WIDTH = 32,
    parameter int C_DIGIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int N = C_WIDTH / C_DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [C_WIDTH-1:0] a_q, b_q, diff_q;
    logic               a_msb_q, b_msb_q;
    logic               carry_q, borrow_q, ovf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [C_DIGIT:0]   dsum;
    logic               last;

    // Single digit-wide adder; the top bit is the carry-out into the next digit.
    function automatic logic [C_DIGIT:0] digit_add(
        input logic [C_DIGIT-1:0] x,
        input logic [C_DIGIT-1:0] y_n,
        input logic               cin
    );
        digit_add = {1'b0, x} + {1'b0, y_n} + {{C_DIGIT{1'b0}}, cin};
    endfunction

    assign dsum = digit_add(a_q[C_DIGIT-1:0], ~b_q[C_DIGIT-1:0], carry_q);
    assign last = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        a_msb_q <= bus.a[C_WIDTH-1];
                        b_msb_q <= bus.b[C_WIDTH-1];
                        cnt_q   <= '0;
                        carry_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Operands shift down so the active digit always sits at bit 0.
                    diff_q[int'(cnt_q)*C_DIGIT +: C_DIGIT] <= dsum[C_DIGIT-1:0];
                    a_q     <= a_q >> C_DIGIT;
                    b_q     <= b_q >> C_DIGIT;
                    carry_q <= dsum[C_DIGIT];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        borrow_q <= ~dsum[C_DIGIT];
                        ovf_q    <= (a_msb_q != b_msb_q) && (dsum[C_DIGIT-1] != a_msb_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle unsigned/two's-complement subtractor computing `a - b` one `C_DIGIT`-bit digit per clock, least-significant digit first. The borrow is held in a register between digits. It is the inverse-direction companion to the team's combinational ripple adder and sits in datapaths where area matters more than latency. Operands enter through a valid/ready handshake, and results leave through a separate valid/ready handshake.

## Interface
- `C_WIDTH`, default 32: operand width in bits. Must be a multiple of `C_DIGIT`.
- `C_DIGIT`, default 4: bits subtracted per cycle. N = `C_WIDTH`/`C_DIGIT` digit cycles; N ≥ 1.
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: operands `a`, `b` are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  `C_WIDTH`: minuend.
- `b`  in  `C_WIDTH`: subtrahend.
- `out_valid`  out  1: result fields are valid.
- `out_ready`  in  1: consumer accepts the result.
- `diff`  out  `C_WIDTH`: (a − b) mod 2^`C_WIDTH`.
- `borrow`  out  1: 1 when a < b as unsigned values.
- `ovf`  out  1: signed overflow, i.e. a[MSB] ≠ b[MSB] and diff[MSB] ≠ a[MSB].

## Operation
- Subtraction is computed as a + ~b + 1.
  - Digit k sums a[k], ~b[k] and a carry-in.
  - The carry-in is 1 for k=0; otherwise it is the registered carry-out of digit k−1.
  - Final borrow = NOT(final carry-out).
- On acceptance, operands are captured into internal shift/hold registers. Input ports are ignored afterwards, so changes to `a`/`b` during RUN have no effect.
- FSM states are IDLE, RUN and DONE.
  - IDLE: `in_ready`=1. `in_valid`=1 → capture operands, digit counter=0, carry=1, go to RUN.
  - RUN: one digit per cycle; its result is written into `diff[k*C_DIGIT +: C_DIGIT]`. After digit N−1, latch `borrow` and `ovf` and go to DONE.
  - DONE: `out_valid`=1. `out_ready`=1 → go to IDLE. Otherwise hold.
- `in_ready` is asserted only in IDLE. `out_valid` is asserted only in DONE. They are never both high.
- `diff`, `borrow` and `ovf` are stable for the whole time `out_valid`=1. They keep their last values after the handshake until the next result is written.
- Only `out_valid` qualifies `diff`; digits written during RUN may be visible early.
- Per-cycle arithmetic is exactly one `C_DIGIT`-bit adder. There is no full-width adder.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces:
  - state=IDLE
  - `in_ready`=1 from the next cycle
  - `out_valid`=0, `diff`=0, `borrow`=0, `ovf`=0
  - counter=0, carry=1
- Reset takes priority over every other event. Reset during RUN or DONE aborts the operation, and no `out_valid` is produced for the aborted operands.
- Input accepted at edge T0 → `out_valid` rises after edge T0+N and is sampled high at edge T0+N+1. Latency is N+1 edges.
- Output handshake at edge Tr → `in_ready`=1 after Tr.
  - The earliest next acceptance is edge Tr+1.
  - Minimum issue interval is N+2 cycles.
- `in_valid` asserted during RUN or DONE is not accepted. The source must hold it until `in_ready`.
- Wrap-around: `diff` wraps modulo 2^`C_WIDTH`. `borrow` reports the wrap.
- `C_DIGIT`=`C_WIDTH` gives N=1, a single RUN cycle.

## Test plan
Bench uses `C_WIDTH`=8, `C_DIGIT`=2 (N=4).
- 8'h05 − 8'h03, `out_ready`=1 → `diff`=8'h02, `borrow`=0, `ovf`=0. `out_valid` is sampled high exactly at the 5th edge after acceptance.
- 8'h03 − 8'h05 → `diff`=8'hFE, `borrow`=1, `ovf`=0. Also 8'h00 − 8'hFF → `diff`=8'h01, `borrow`=1, `ovf`=0.
- 8'h80 − 8'h01 → `diff`=8'h7F, `borrow`=0, `ovf`=1. Also 8'h7F − 8'hFF → `diff`=8'h80, `borrow`=1, `ovf`=1.
- Back-pressure: 8'hAA − 8'h55 with `out_ready`=0 for 10 cycles.
  - Outputs hold at `diff`=8'h55, `borrow`=0, `ovf`=1 with `out_valid`=1 and `in_ready`=0 throughout.
  - A new `in_valid` held during this time is not accepted until the cycle after `out_ready`=1.
- Reset mid-RUN: drive `rst_n`=0 for one edge two cycles after acceptance of 8'h10 − 8'h01.
  - After that edge, `out_valid`=0, `diff`=0, `in_ready`=1.
  - No result appears for the aborted operands.
  - A following 8'h10 − 8'h01 yields 8'h0F.
- Random back-to-back stream (≥1000 pairs, random `in_valid`/`out_ready`) → every result matches the reference model (a−b) mod 256, borrow=(a<b), signed overflow.
  - Results arrive in order, with no drops or duplicates.
  - Issue interval is ≥ 6 cycles.
